// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction fields, status flags and control outputs between controller and datapath
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, Zero, MemReady;
  logic MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, IllegalInstr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [CNT_W-1:0] RetireCnt;
  modport master (
    input op, funct3, funct7b5, Zero, MemReady,
    output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, IllegalInstr,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RetireCnt
  );
  modport slave (
    output op, funct3, funct7b5, Zero, MemReady,
    input MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, IllegalInstr,
    input ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RetireCnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the shared-memory multicycle RV32I datapath
module multicycle_ctrl #(
  parameter bit STALL_EN = 1'b1,
  parameter bit TRAP_HALT = 1'b1,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, JAL, BEQ, TRAP
  } state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic rdy, mem_req, mem_write, adr_src, ir_write, pc_update, branch, reg_write, illegal, retire;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] f3_ctl;
  assign rdy = STALL_EN ? bus.MemReady : 1'b1;
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_write = 1'b0;
    adr_src = 1'b0;
    ir_write = 1'b0;
    pc_update = 1'b0;
    branch = 1'b0;
    reg_write = 1'b0;
    illegal = 1'b0;
    result_src = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        alu_src_b = 2'b10;
        result_src = 2'b10;
        ir_write = rdy;
        pc_update = rdy;
        state_d = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011: state_d = EXECR;
          7'b0010011: state_d = EXECI;
          7'b1100011: state_d = BEQ;
          7'b1101111: state_d = JAL;
          default: state_d = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d = bus.op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        state_d = rdy ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write = 1'b1;
        state_d = FETCH;
      end
      MEMWRITE: begin
        mem_req = 1'b1;
        mem_write = 1'b1;
        adr_src = 1'b1;
        state_d = rdy ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op = 2'b10;
        state_d = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d = ALUWB;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op = 2'b01;
        branch = 1'b1;
        state_d = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
        state_d = TRAP_HALT ? TRAP : FETCH;
      end
      default: state_d = FETCH;
    endcase
  end
  assign retire = (state_d == FETCH) &&
                  (state_q == MEMWB || state_q == MEMWRITE || state_q == ALUWB || state_q == BEQ);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  // sub only for R-type (op[5]=1); I-type with bit30 set still adds
  assign f3_ctl = bus.funct3 == 3'b000 ? ((bus.funct7b5 & bus.op[5]) ? 3'b001 : 3'b000) :
                  bus.funct3 == 3'b010 ? 3'b101 :
                  bus.funct3 == 3'b110 ? 3'b011 :
                  bus.funct3 == 3'b111 ? 3'b010 :
                  bus.funct3 == 3'b101 ? 3'b111 : 3'b000;
  assign bus.ALUControl = alu_op == 2'b00 ? 3'b000 : alu_op == 2'b01 ? 3'b001 :
                          alu_op == 2'b10 ? f3_ctl : 3'b000;
  assign bus.ImmSrc = bus.op == 7'b0100011 ? 2'b01 : bus.op == 7'b1100011 ? 2'b10 :
                      bus.op == 7'b1101111 ? 2'b11 : 2'b00;
  assign bus.MemReq = mem_req & ~reset;
  assign bus.MemWrite = mem_write & ~reset;
  assign bus.IRWrite = ir_write & ~reset;
  assign bus.PCWrite = (pc_update | (branch & bus.Zero)) & ~reset;
  assign bus.RegWrite = reg_write & ~reset;
  assign bus.IllegalInstr = illegal & ~reset;
  assign bus.AdrSrc = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA = alu_src_a;
  assign bus.ALUSrcB = alu_src_b;
  assign bus.RetireCnt = cnt_q;
endmodule
